wb_trace_checker: RTL and testbench

Write-back trace checker: the consuming end of the core's debug write-back interface (`debug_wb_*`). It captures every retired register write from `myCPU` into a small FIFO, pairs it with golden entries from a ready/valid stream, and raises sticky pass/fail status with diagnostic fields. It sits beside the core in the trace build of `miniRV_SoC`, driven by the same clock and reset.

---
 rtl/wb_trace_checker_pkg.sv | 33 +++
 rtl/wb_trace_checker_trace_fifo.sv | 60 ++++++
 rtl/wb_trace_checker.sv | 147 ++++++++++++++
 tb/tb_wb_trace_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_checker_pkg.sv
// Shared types and constants for the write-back trace checker.
// Defines the entry layout, the FSM states and the error codes.
package wb_trace_checker_pkg;

  localparam int TC_ENTRY_W = 69;

  typedef enum logic [1:0] {
    TC_ST_RUN  = 2'd0,
    TC_ST_PASS = 2'd1,
    TC_ST_FAIL = 2'd2
  } tc_state_e;

  typedef enum logic [1:0] {
    TC_ERR_NONE     = 2'd0,
    TC_ERR_MISMATCH = 2'd1,
    TC_ERR_OVERFLOW = 2'd2,
    TC_ERR_EXTRA    = 2'd3
  } tc_err_e;

  // One retired register write: {pc, destination register, value}.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] value;
  } tc_entry_t;

  // A write is traced only when it really changes architectural state.
  function automatic logic is_capture(input logic have_inst, input logic ena,
                                      input logic [4:0] rd);
    return have_inst && ena && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_trace_checker_trace_fifo.sv
// Synchronous capture FIFO for the trace checker.
// Push at full is accepted only when a pop happens in the same cycle.
module trace_fifo
  import wb_trace_checker_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = TC_ENTRY_W
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge cpu_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (cpu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge cpu_clk) begin
    // NOTE: storage is deliberately not reset; the pointers and count define
    // which words are valid, so stale data is never observed.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Write-back trace checker: captures retired register writes into a FIFO
// and pairs them with a golden ready/valid stream, reporting sticky status.
// Optional macro TRACE_CHECK_PC_EN adds PC equality to the match.
module wb_trace_checker
  import wb_trace_checker_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        debug_wb_have_inst,
  input  logic [31:0] debug_wb_pc,
  input  logic        debug_wb_ena,
  input  logic [4:0]  debug_wb_reg,
  input  logic [31:0] debug_wb_value,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_reg,
  input  logic [31:0] gold_value,
  input  logic        gold_last,
  output logic        chk_pass,
  output logic        chk_fail,
  output logic [1:0]  chk_err_code,
  output logic [31:0] chk_count,
  output logic [31:0] chk_err_pc,
  output logic [31:0] chk_exp_value,
  output logic [31:0] chk_got_value
);

  tc_state_e   state, state_d;
  tc_err_e     err_code, err_code_d;
  tc_entry_t   cap_entry, head;
  logic [TC_ENTRY_W-1:0] head_bits;
  logic        capture, push, pop, full, empty, match, pc_ok;
  logic        pass_d, fail_d;
  logic [31:0] count_d, err_pc_d, exp_d, got_d;

  assign capture   = is_capture(debug_wb_have_inst, debug_wb_ena, debug_wb_reg);
  assign cap_entry = '{pc: debug_wb_pc, rd: debug_wb_reg, value: debug_wb_value};
  assign head      = tc_entry_t'(head_bits);

`ifdef TRACE_CHECK_PC_EN
  assign pc_ok = (head.pc == gold_pc);
`else
  assign pc_ok = 1'b1;
  logic unused_gold_pc;
  assign unused_gold_pc = ^gold_pc;
`endif

  assign match = pc_ok && (head.rd == gold_reg) && (head.value == gold_value);

  trace_fifo #(.DEPTH(DEPTH), .W(TC_ENTRY_W)) u_fifo (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .push     (push),
    .push_data(cap_entry),
    .pop      (pop),
    .pop_data (head_bits),
    .full     (full),
    .empty    (empty)
  );

  // Next-state, FIFO control and next status values.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d    = state;
    gold_ready = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    pass_d     = chk_pass;
    fail_d     = chk_fail;
    err_code_d = err_code;
    count_d    = chk_count;
    err_pc_d   = chk_err_pc;
    exp_d      = chk_exp_value;
    got_d      = chk_got_value;
    case (state)
      TC_ST_RUN: begin
        gold_ready = !empty;
        pop        = gold_ready && gold_valid;
        push       = capture;
        if (pop && !match) begin
          state_d    = TC_ST_FAIL;
          fail_d     = 1'b1;
          err_code_d = TC_ERR_MISMATCH;
          err_pc_d   = head.pc;
          exp_d      = gold_value;
          got_d      = head.value;
        end else if (capture && full && !pop) begin
          state_d    = TC_ST_FAIL;
          fail_d     = 1'b1;
          err_code_d = TC_ERR_OVERFLOW;
          err_pc_d   = debug_wb_pc;
          exp_d      = '0;
          got_d      = '0;
        end else if (pop) begin
          count_d = (chk_count == 32'hFFFF_FFFF) ? chk_count : chk_count + 32'd1;
          if (gold_last) begin
            state_d = TC_ST_PASS;
            pass_d  = 1'b1;
          end
        end
      end
      TC_ST_PASS: begin
        // Older buffered entries are reported before a fresh capture.
        if (!empty || capture) begin
          state_d    = TC_ST_FAIL;
          fail_d     = 1'b1;
          err_code_d = TC_ERR_EXTRA;
          err_pc_d   = empty ? debug_wb_pc : head.pc;
          exp_d      = '0;
          got_d      = empty ? debug_wb_value : head.value;
        end
      end
      TC_ST_FAIL: state_d = TC_ST_FAIL;
      default:    state_d = TC_ST_FAIL;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state         <= TC_ST_RUN;
      chk_pass      <= 1'b0;
      chk_fail      <= 1'b0;
      err_code      <= TC_ERR_NONE;
      chk_count     <= '0;
      chk_err_pc    <= '0;
      chk_exp_value <= '0;
      chk_got_value <= '0;
    end else begin
      state         <= state_d;
      chk_pass      <= pass_d;
      chk_fail      <= fail_d;
      err_code      <= err_code_d;
      chk_count     <= count_d;
      chk_err_pc    <= err_pc_d;
      chk_exp_value <= exp_d;
      chk_got_value <= got_d;
    end
  end

  assign chk_err_code = err_code;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed self-checking bench for wb_trace_checker (DEPTH = 8).
module tb_wb_trace_checker;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        debug_wb_have_inst, debug_wb_ena;
  logic [31:0] debug_wb_pc, debug_wb_value;
  logic [4:0]  debug_wb_reg;
  logic        gold_valid, gold_ready, gold_last;
  logic [31:0] gold_pc, gold_value;
  logic [4:0]  gold_reg;
  logic        chk_pass, chk_fail;
  logic [1:0]  chk_err_code;
  logic [31:0] chk_count, chk_err_pc, chk_exp_value, chk_got_value;

  int total = 0;
  int bad   = 0;

  always #5 cpu_clk = ~cpu_clk;

  wb_trace_checker #(.DEPTH(8)) dut (
    .cpu_clk           (cpu_clk),
    .cpu_rst           (cpu_rst),
    .debug_wb_have_inst(debug_wb_have_inst),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_ena      (debug_wb_ena),
    .debug_wb_reg      (debug_wb_reg),
    .debug_wb_value    (debug_wb_value),
    .gold_valid        (gold_valid),
    .gold_ready        (gold_ready),
    .gold_pc           (gold_pc),
    .gold_reg          (gold_reg),
    .gold_value        (gold_value),
    .gold_last         (gold_last),
    .chk_pass          (chk_pass),
    .chk_fail          (chk_fail),
    .chk_err_code      (chk_err_code),
    .chk_count         (chk_count),
    .chk_err_pc        (chk_err_pc),
    .chk_exp_value     (chk_exp_value),
    .chk_got_value     (chk_got_value)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    debug_wb_have_inst = 1'b0; debug_wb_ena = 1'b0; debug_wb_reg = '0;
    debug_wb_pc = '0; debug_wb_value = '0;
    gold_valid = 1'b0; gold_pc = '0; gold_reg = '0; gold_value = '0; gold_last = 1'b0;
  endtask

  task automatic wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
    debug_wb_have_inst = 1'b1; debug_wb_ena = 1'b1;
    debug_wb_pc = pc; debug_wb_reg = rd; debug_wb_value = val;
  endtask

  task automatic wb_off();
    debug_wb_have_inst = 1'b0; debug_wb_ena = 1'b0; debug_wb_reg = '0;
  endtask

  task automatic gold(input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] val, input logic last);
    gold_valid = 1'b1; gold_pc = pc; gold_reg = rd; gold_value = val; gold_last = last;
  endtask

  task automatic do_reset();
    idle_inputs();
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    cpu_rst = 1'b1;
    step();
    step();
    // Reset state
    check("rst_pass",  32'(chk_pass), 32'd0);
    check("rst_fail",  32'(chk_fail), 32'd0);
    check("rst_ready", 32'(gold_ready), 32'd0);
    check("rst_code",  32'(chk_err_code), 32'd0);
    check("rst_count", chk_count, 32'd0);
    check("rst_errpc", chk_err_pc, 32'd0);
    cpu_rst = 1'b0;

    // Three matching writes, pipelined with the golden stream
    wb(32'h0, 5'd1, 32'd5); step();
    check("t1_ready", 32'(gold_ready), 32'd1);
    wb(32'h4, 5'd2, 32'd7);  gold(32'h0, 5'd1, 32'd5, 1'b0); step();
    wb(32'h8, 5'd3, 32'd12); gold(32'h4, 5'd2, 32'd7, 1'b0); step();
    check("t1_mid_pass",  32'(chk_pass), 32'd0);
    check("t1_mid_count", chk_count, 32'd2);
    wb_off(); gold(32'h8, 5'd3, 32'd12, 1'b1); step();
    gold_valid = 1'b0;
    check("t1_pass",  32'(chk_pass), 32'd1);
    check("t1_fail",  32'(chk_fail), 32'd0);
    check("t1_count", chk_count, 32'd3);
    check("t1_code",  32'(chk_err_code), 32'd0);
    check("t1_ready", 32'(gold_ready), 32'd0);

    // Writes to x0 and disabled writes are not captured
    do_reset();
    wb(32'h0, 5'd0, 32'd9); step();
    check("t2_ready_x0", 32'(gold_ready), 32'd0);
    wb(32'h4, 5'd3, 32'd1); debug_wb_ena = 1'b0; step();
    wb_off();
    check("t2_ready_ena", 32'(gold_ready), 32'd0);
    check("t2_count", chk_count, 32'd0);
    check("t2_fail",  32'(chk_fail), 32'd0);

    // Value mismatch
    do_reset();
    wb(32'h20, 5'd5, 32'h11); step();
    wb_off(); gold(32'h20, 5'd5, 32'h10, 1'b0); step();
    check("t3_fail",  32'(chk_fail), 32'd1);
    check("t3_code",  32'(chk_err_code), 32'd1);
    check("t3_errpc", chk_err_pc, 32'h20);
    check("t3_exp",   chk_exp_value, 32'h10);
    check("t3_got",   chk_got_value, 32'h11);
    // Further traffic must not disturb the frozen status
    wb(32'h40, 5'd6, 32'h99); gold(32'h40, 5'd6, 32'h99, 1'b1); step();
    check("t3_ready_frozen", 32'(gold_ready), 32'd0);
    step();
    wb_off(); gold_valid = 1'b0;
    check("t3_code_hold",  32'(chk_err_code), 32'd1);
    check("t3_errpc_hold", chk_err_pc, 32'h20);
    check("t3_got_hold",   chk_got_value, 32'h11);
    check("t3_count_hold", chk_count, 32'd0);
    check("t3_pass_hold",  32'(chk_pass), 32'd0);

    // Overflow: nine writes with no golden traffic
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wb(32'(i * 4), 5'(i + 1), 32'h100 + 32'(i)); step();
    end
    check("t4_full_nofail", 32'(chk_fail), 32'd0);
    wb(32'h20, 5'd9, 32'h108); step();
    wb_off();
    check("t4_fail",  32'(chk_fail), 32'd1);
    check("t4_code",  32'(chk_err_code), 32'd2);
    check("t4_errpc", chk_err_pc, 32'h20);
    check("t4_exp",   chk_exp_value, 32'd0);
    check("t4_got",   chk_got_value, 32'd0);

    // Simultaneous push and pop at full: no overflow, then drain to PASS
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wb(32'(i * 4), 5'(i + 1), 32'h100 + 32'(i)); step();
    end
    wb(32'h20, 5'd9, 32'h108); gold(32'h0, 5'd1, 32'h100, 1'b0); step();
    wb_off();
    check("t4b_nofail", 32'(chk_fail), 32'd0);
    check("t4b_count1", chk_count, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      gold(32'(k * 4), 5'(k + 1), 32'h100 + 32'(k), k == 8); step();
    end
    gold_valid = 1'b0;
    check("t4b_pass",  32'(chk_pass), 32'd1);
    check("t4b_count", chk_count, 32'd9);
    check("t4b_fail",  32'(chk_fail), 32'd0);

    // Extra write after PASS
    do_reset();
    wb(32'h0, 5'd1, 32'd1); step();
    wb(32'h4, 5'd2, 32'd2); gold(32'h0, 5'd1, 32'd1, 1'b0); step();
    wb_off(); gold(32'h4, 5'd2, 32'd2, 1'b1); step();
    gold_valid = 1'b0;
    check("t5_pass", 32'(chk_pass), 32'd1);
    wb(32'h30, 5'd7, 32'h55); step();
    wb_off();
    check("t5_fail",  32'(chk_fail), 32'd1);
    check("t5_code",  32'(chk_err_code), 32'd3);
    check("t5_errpc", chk_err_pc, 32'h30);
    check("t5_got",   chk_got_value, 32'h55);
    check("t5_exp",   chk_exp_value, 32'd0);

    // Last-match coinciding with a new capture: PASS, then code 3
    do_reset();
    wb(32'h40, 5'd1, 32'd3); step();
    wb(32'h44, 5'd2, 32'd4); gold(32'h40, 5'd1, 32'd3, 1'b1); step();
    wb_off(); gold_valid = 1'b0;
    check("t5b_pass",    32'(chk_pass), 32'd1);
    check("t5b_nofail",  32'(chk_fail), 32'd0);
    step();
    check("t5b_code",  32'(chk_err_code), 32'd3);
    check("t5b_errpc", chk_err_pc, 32'h44);
    check("t5b_got",   chk_got_value, 32'd4);

    // PC differs, reg and value equal
    do_reset();
    wb(32'h8, 5'd4, 32'h77); step();
    wb_off(); gold(32'h4, 5'd4, 32'h77, 1'b1); step();
    gold_valid = 1'b0;
`ifdef TRACE_CHECK_PC_EN
    check("t6_fail",  32'(chk_fail), 32'd1);
    check("t6_code",  32'(chk_err_code), 32'd1);
    check("t6_errpc", chk_err_pc, 32'h8);
`else
    check("t6_pass",  32'(chk_pass), 32'd1);
    check("t6_count", chk_count, 32'd1);
    check("t6_code",  32'(chk_err_code), 32'd0);
`endif

    // Reset mid-run with a buffered entry and golden data offered
    do_reset();
    wb(32'h10, 5'd1, 32'd1); step();
    wb(32'h14, 5'd2, 32'd2); gold(32'h10, 5'd1, 32'd1, 1'b0); step();
    wb_off(); gold(32'h14, 5'd9, 32'd9, 1'b0);
    check("t7_pre_count", chk_count, 32'd1);
    check("t7_pre_ready", 32'(gold_ready), 32'd1);
    cpu_rst = 1'b1; step();
    check("t7_ready", 32'(gold_ready), 32'd0);
    check("t7_count", chk_count, 32'd0);
    check("t7_fail",  32'(chk_fail), 32'd0);
    check("t7_pass",  32'(chk_pass), 32'd0);
    cpu_rst = 1'b0; step();
    check("t7_after_ready", 32'(gold_ready), 32'd0);
    check("t7_after_fail",  32'(chk_fail), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
